// File: rtl/calcutec_alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calcutec_alu_pkg: opcodes, error result and sequencer FSM encoding.
// Optional divide (ALU_DIV_EN) widens the legal opcode range and adds ST_DIV.
// Revision: 1.0
// ----------------------------------------------------------------------------
package calcutec_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_LSL = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;

`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_LAST_LEGAL = OP_DIV;
`else
  localparam logic [3:0] OP_LAST_LEGAL = OP_LSR;
`endif

  localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DIV   = 2'd3
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_divider: unsigned restoring divider, one quotient bit per cycle.
// Present only when ALU_DIV_EN is defined. Revision: 1.0
// ----------------------------------------------------------------------------
`ifdef ALU_DIV_EN
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_fit      = ~w_diff[WIDTH];
  assign o_busy     = r_busy;
  // o_done marks the cycle whose step yields the final quotient bit
  assign o_done     = r_busy && (r_cnt == CW'(1));
  assign o_quotient = {r_quo[WIDTH-2:0], w_fit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= CW'(WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo  <= o_quotient;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_cmd_sequencer: drives the calculator ALU for one command at a time and
// buffers the response; ALU_DIV_EN adds an internal divider. Revision: 1.0
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
  import calcutec_alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [3:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic             i_cmd_use_acc,
  output logic [WIDTH-1:0] o_alu_dat1,
  output logic [WIDTH-1:0] o_alu_dat2,
  output logic [3:0]       o_alu_control,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_z,
  output logic             o_rsp_n,
  output logic             o_rsp_err,
  output logic [WIDTH-1:0] o_acc
);

  localparam logic [WIDTH-1:0] c_err = WIDTH'(ERR_RESULT);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_dat1;
  logic [WIDTH-1:0] r_dat2;
  logic [3:0]       r_ctl;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_z;
  logic             r_rsp_n;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_legal;
  logic             w_reject;
  logic             w_to_alu;
  logic [WIDTH-1:0] w_opa;
  logic             w_cap_en;
  logic [WIDTH-1:0] w_cap_val;

  assign w_accept = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_opa    = i_cmd_use_acc ? r_acc : i_cmd_a;
  assign w_legal  = (i_cmd_op <= OP_LAST_LEGAL);

`ifdef ALU_DIV_EN
  logic             w_is_div;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic             w_div_fin;
  logic [WIDTH-1:0] w_div_quot;

  assign w_is_div    = (i_cmd_op == OP_DIV);
  // A zero divisor is answered as an error and never starts the divider
  assign w_reject    = !w_legal || (w_is_div && (i_cmd_b == '0));
  assign w_to_alu    = w_legal && !w_is_div;
  assign w_div_start = w_accept && w_is_div && (i_cmd_b != '0);
  assign w_div_fin   = w_div_busy && w_div_done && (r_state == ST_DIV);

  alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_opa),
    .i_divisor  (i_cmd_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_quot)
  );

  assign w_cap_en  = ((r_state == ST_DRIVE) && (r_cnt == 4'd1)) || w_div_fin;
  assign w_cap_val = w_div_fin ? w_div_quot : i_alu_result;
`else
  assign w_reject  = !w_legal;
  assign w_to_alu  = w_legal;
  assign w_cap_en  = (r_state == ST_DRIVE) && (r_cnt == 4'd1);
  assign w_cap_val = i_alu_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (w_reject)      w_next = ST_RESP;
          else if (w_to_alu) w_next = ST_DRIVE;
`ifdef ALU_DIV_EN
          else               w_next = ST_DIV;
`endif
        end
      end
      ST_DRIVE: if (r_cnt == 4'd1) w_next = ST_RESP;
`ifdef ALU_DIV_EN
      ST_DIV:   if (w_div_fin) w_next = ST_RESP;
`endif
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ALU drive registers only move on a legal ALU command, so control never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dat1       <= '0;
      r_dat2       <= '0;
      r_ctl        <= '0;
      r_rsp_result <= '0;
      r_rsp_z      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_acc        <= '0;
    end else begin
      if (w_accept) begin
        if (w_reject) begin
          r_rsp_result <= c_err;
          r_rsp_err    <= 1'b1;
          r_rsp_z      <= 1'b0;
          r_rsp_n      <= 1'b1;
        end else if (w_to_alu) begin
          r_dat1 <= w_opa;
          r_dat2 <= i_cmd_b;
          r_ctl  <= i_cmd_op;
          r_cnt  <= 4'(SETTLE_CYCLES);
        end
      end
      if (r_state == ST_DRIVE) r_cnt <= r_cnt - 4'd1;
      if (w_cap_en) begin
        r_rsp_result <= w_cap_val;
        r_rsp_z      <= (w_cap_val == '0);
        r_rsp_n      <= w_cap_val[WIDTH-1];
        r_rsp_err    <= 1'b0;
        r_acc        <= w_cap_val;
      end
    end
  end

  assign o_alu_dat1    = r_dat1;
  assign o_alu_dat2    = r_dat2;
  assign o_alu_control = r_ctl;
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_z       = r_rsp_z;
  assign o_rsp_n       = r_rsp_n;
  assign o_rsp_err     = r_rsp_err;
  assign o_acc         = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer: randomized bench with a transaction-level model of the
// sequencer and a settle-aware ALU stand-in. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int W = 32;
  localparam int S = 4;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [W-1:0] ERR = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_use_acc = 1'b0;
  logic         rsp_ready = 1'b0;
  logic [3:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_ready, rsp_valid, rsp_z, rsp_n, rsp_err;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_dat1, alu_dat2, alu_result, rsp_result, acc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_a       (cmd_a),
    .i_cmd_b       (cmd_b),
    .i_cmd_use_acc (cmd_use_acc),
    .o_alu_dat1    (alu_dat1),
    .o_alu_dat2    (alu_dat2),
    .o_alu_control (alu_control),
    .i_alu_result  (alu_result),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_result  (rsp_result),
    .o_rsp_z       (rsp_z),
    .o_rsp_n       (rsp_n),
    .o_rsp_err     (rsp_err),
    .o_acc         (acc)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x * y;
      4'd3:    return x | y;
      4'd4:    return x << y[4:0];
      4'd5:    return x >> y[4:0];
      default: return '0;
    endcase
  endfunction

  // ALU stand-in: answers wrongly until its inputs have been stable long enough
  int               stab = 0;
  logic [2*W+3:0]   prev_in = '0;
  always @(negedge clk) begin
    if ({alu_control, alu_dat1, alu_dat2} != prev_in) stab = 0;
    else if (stab < 1000) stab = stab + 1;
    prev_in = {alu_control, alu_dat1, alu_dat2};
  end
  assign alu_result = (stab >= S - 1) ? alu_f(alu_control, alu_dat1, alu_dat2)
                                      : ~alu_f(alu_control, alu_dat1, alu_dat2);

  // Transaction-level reference: one command in flight, response after a fixed wait
  logic         m_busy = 1'b0, m_rspv = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_acc = '0, m_d1 = '0, m_d2 = '0, m_res = '0, m_pend = '0, m_a = '0;
  logic [3:0]   m_ctl = '0;
  int           m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_rspv = 0; m_err = 0; m_acc = '0; m_d1 = '0; m_d2 = '0;
      m_ctl = '0; m_res = '0; m_pend = '0; m_wait = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_a    = cmd_use_acc ? m_acc : cmd_a;
        m_busy = 1'b1;
        if (cmd_op <= 4'd5) begin
          m_d1 = m_a; m_d2 = cmd_b; m_ctl = cmd_op;
          m_pend = alu_f(cmd_op, m_a, cmd_b);
          m_wait = S;
        end else if (DIV_EN && cmd_op == 4'd6 && cmd_b != '0) begin
          m_pend = m_a / cmd_b;
          m_wait = W;
        end else begin
          m_rspv = 1'b1; m_res = ERR; m_err = 1'b1;
        end
      end
    end else if (!m_rspv) begin
      m_wait--;
      if (m_wait == 0) begin
        m_rspv = 1'b1; m_res = m_pend; m_err = 1'b0; m_acc = m_pend;
      end
    end else if (rsp_ready) begin
      m_rspv = 1'b0; m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_rspv);
      chk("acc", acc, m_acc);
      chk("alu_dat1", alu_dat1, m_d1);
      chk("alu_dat2", alu_dat2, m_d2);
      chk("alu_control", alu_control, m_ctl);
      if (m_rspv) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_z", rsp_z, m_res == '0);
        chk("rsp_n", rsp_n, m_res[W-1]);
      end
    end
  end

  // lat = edges after the acceptance edge until rsp_valid is seen
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ua, input int hold,
                      output logic [W-1:0] r, output logic e, output logic z, output logic n,
                      output int lat);
    int t;
    r = '0; e = 1'b0; z = 1'b0; n = 1'b0; lat = -1; t = 0;
    while (!cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: got 0 expected 1");
      return;
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    // junk on the command port while busy must be ignored
    while (!rsp_valid && lat < 200) begin
      cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 4'($urandom_range(0, 15));
      cmd_a = $urandom; cmd_b = $urandom; cmd_use_acc = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      cmd_valid = 1'b0;
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: got 0 expected 1");
      return;
    end
    r = rsp_result; e = rsp_err; z = rsp_z; n = rsp_n;
    repeat (hold) begin
      cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, ra, rb;
    logic         e, z, n;
    int           lat, k, seen;
    logic [3:0]   op;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_dat1", alu_dat1, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    send(4'd0, 7, 5, 1'b0, 0, r, e, z, n, lat);
    chk("add_result", r, 12);
    chk("add_flags", {29'd0, e, z, n}, 0);
    chk("add_latency", lat, S);
    chk("add_acc", acc, 12);
    chk("add_ports", {alu_control, alu_dat1[7:0], alu_dat2[7:0]}, 20'h00705);

    send(4'd2, 32'hDEAD, 3, 1'b1, 4, r, e, z, n, lat);
    chk("chain_result", r, 36);
    chk("chain_acc", acc, 36);

    send(4'd1, 3, 5, 1'b0, 1, r, e, z, n, lat);
    chk("sub_neg_result", r, 32'hFFFF_FFFE);
    chk("sub_neg_n", n, 1);
    send(4'd1, 9, 9, 1'b0, 0, r, e, z, n, lat);
    chk("sub_zero_result", r, 0);
    chk("sub_zero_z", z, 1);

    send(4'd9, 1, 2, 1'b0, 2, r, e, z, n, lat);
    chk("illegal_result", r, ERR);
    chk("illegal_err", e, 1);
    chk("illegal_latency", lat, 0);
    chk("illegal_acc", acc, 0);
    chk("illegal_ports", {alu_control, alu_dat1[7:0], alu_dat2[7:0]}, 20'h10909);

    // reset while the ALU is being driven: command is dropped
    cmd_op = 4'd0; cmd_a = 1; cmd_b = 2; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("drive_busy", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_outputs", {rsp_valid, rsp_err, rsp_z, rsp_n, alu_control}, 0);
    chk("mid_rst_alu_dat1", alu_dat1, 0);
    chk("mid_rst_acc", acc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (S + 3) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    chk("no_rsp_after_reset", seen, 0);
    send(4'd0, 2, 3, 1'b0, 0, r, e, z, n, lat);
    chk("rerun_result", r, 5);
    chk("rerun_latency", lat, S);

`ifdef ALU_DIV_EN
    send(4'd6, 100, 7, 1'b0, 0, r, e, z, n, lat);
    chk("div_result", r, 14);
    chk("div_latency", lat, W);
    send(4'd6, 5, 0, 1'b0, 0, r, e, z, n, lat);
    chk("div0_result", r, ERR);
    chk("div0_err", e, 1);
`endif

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 9);
      op = (k < 7) ? 4'($urandom_range(0, 5)) : ((k < 9) ? 4'd6 : 4'($urandom_range(7, 15)));
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      send(op, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), r, e, z, n, lat);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
